// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator controller.
// Floors are handled as one-hot vectors throughout.
package elevator_pkg;

    localparam int FLOORS = 5;

    typedef logic [FLOORS-1:0] floor_vec_t;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        DOOR
    } state_e;

    typedef enum logic {
        UP,
        DOWN
    } dir_e;

    function automatic logic any_above(
        input floor_vec_t pend,
        input floor_vec_t floor_oh
    );
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            for (int j = 0; j < i; j++) begin
                hit = hit | (floor_oh[j] & pend[i]);
            end
        end
        return hit;
    endfunction

    function automatic logic any_below(
        input floor_vec_t pend,
        input floor_vec_t floor_oh
    );
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            for (int j = i + 1; j < FLOORS; j++) begin
                hit = hit | (floor_oh[j] & pend[i]);
            end
        end
        return hit;
    endfunction

    // Saturates at the end floors so the one-hot value can never vanish.
    function automatic floor_vec_t step_floor(
        input floor_vec_t floor_oh,
        input dir_e       dir
    );
        floor_vec_t nxt;
        nxt = floor_oh;
        if (dir == UP) begin
            if (!floor_oh[FLOORS-1]) nxt = floor_oh << 1;
        end else begin
            if (!floor_oh[0]) nxt = floor_oh >> 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter shared by travel and door dwell.
// tc is high whenever the count has reached zero.
module elev_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/elevator_ctrl.sv
// SCAN collective-control elevator sequencer: request latch,
// IDLE/MOVE/DOOR FSM, one-hot floor register and shared timer.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 50_000_000,
    parameter int DOOR_CYCLES   = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] req,
    output logic [FLOORS-1:0] floor_oh,
    output logic              moving_up,
    output logic              moving_down,
    output logic              door_open,
    output logic [FLOORS-1:0] pending
);

    localparam int MAXC = (TRAVEL_CYCLES > DOOR_CYCLES) ?
                          TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW   = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);

    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);

    state_e     state_q;
    state_e     state_d;
    dir_e       dir_q;
    dir_e       dir_d;
    floor_vec_t floor_q;
    floor_vec_t floor_d;
    floor_vec_t pending_q;
    floor_vec_t pending_d;
    floor_vec_t clr;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_tc;
    logic          above;
    logic          below;
    logic          here;
    logic          fwd;
    logic          rev;

    elev_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_comb begin
        above = any_above(pending_q, floor_q);
        below = any_below(pending_q, floor_q);
        here  = |(pending_q & floor_q);
        fwd   = (dir_q == UP) ? above : below;
        rev   = (dir_q == UP) ? below : above;
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        floor_d  = floor_q;
        tmr_load = 1'b0;
        tmr_val  = TRAVEL_LOAD;

        unique case (state_q)
            IDLE: begin
                if (here) begin
                    state_d  = DOOR;
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_LOAD;
                end else if (fwd) begin
                    state_d  = MOVE;
                    tmr_load = 1'b1;
                end else if (rev) begin
                    dir_d    = (dir_q == UP) ? DOWN : UP;
                    state_d  = MOVE;
                    tmr_load = 1'b1;
                end
            end
            MOVE: begin
                if (tmr_tc) begin
                    floor_d  = step_floor(floor_q, dir_q);
                    tmr_load = 1'b1;
                    if (|(pending_q & floor_d)) begin
                        state_d = DOOR;
                        tmr_val = DOOR_LOAD;
                    end
                end
            end
            DOOR: begin
                if (tmr_tc) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Hall calls at the open door are absorbed, including on the last dwell cycle.
    always_comb begin
        clr = '0;
        if (state_q == DOOR || state_d == DOOR) begin
            clr = floor_d;
        end
        pending_d = (pending_q | req) & ~clr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dir_q     <= UP;
            floor_q   <= floor_vec_t'(1);
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
        end
    end

    assign floor_oh    = floor_q;
    assign pending     = pending_q;
    assign door_open   = (state_q == DOOR);
    assign moving_up   = (state_q == MOVE) && (dir_q == UP);
    assign moving_down = (state_q == MOVE) && (dir_q == DOWN);

endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: floor-number model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_elevator_ctrl;

    localparam int TC = 4;
    localparam int DC = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] req = 5'b0;
    logic [4:0] floor_oh;
    logic [4:0] pending;
    logic       moving_up;
    logic       moving_down;
    logic       door_open;

    int checks   = 0;
    int failures = 0;

    // Model: floor as number 1..5, mode 0=idle 1=travel 2=door, up-counting timer.
    int       m_floor = 1;
    int       m_mode  = 0;
    int       m_t     = 0;
    bit       m_up    = 1'b1;
    bit [4:0] m_pend  = 5'b0;
    bit       m_valid = 1'b0;

    elevator_ctrl #(
        .TRAVEL_CYCLES (TC),
        .DOOR_CYCLES   (DC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .floor_oh    (floor_oh),
        .moving_up   (moving_up),
        .moving_down (moving_down),
        .door_open   (door_open),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    function automatic bit [4:0] oh(input int f);
        return 5'd1 << (f - 1);
    endfunction

    function automatic bit beyond(input bit [4:0] p, input int f, input bit up);
        bit hit;
        hit = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if ((up ? (k > f) : (k < f)) && (|(p & oh(k)))) hit = 1'b1;
        end
        return hit;
    endfunction

    always @(posedge clk) begin : model
        bit [4:0] old_p;
        bit [4:0] new_p;
        int nf;
        int nm;
        if (rst) begin
            m_floor = 1;
            m_mode  = 0;
            m_t     = 0;
            m_up    = 1'b1;
            m_pend  = 5'b0;
            m_valid = 1'b1;
        end else begin
            old_p = m_pend;
            new_p = m_pend | req;
            nf    = m_floor;
            nm    = m_mode;
            case (m_mode)
                0: begin
                    m_t = 0;
                    if (|(old_p & oh(m_floor))) nm = 2;
                    else if (beyond(old_p, m_floor, m_up)) nm = 1;
                    else if (beyond(old_p, m_floor, !m_up)) begin
                        m_up = !m_up;
                        nm   = 1;
                    end
                end
                1: begin
                    if (m_t == TC - 1) begin
                        m_t = 0;
                        nf  = m_up ? m_floor + 1 : m_floor - 1;
                        if (|(old_p & oh(nf))) nm = 2;
                    end else begin
                        m_t++;
                    end
                end
                default: begin
                    if (m_t == DC - 1) begin
                        m_t = 0;
                        nm  = 0;
                    end else begin
                        m_t++;
                    end
                end
            endcase
            if (m_mode == 2 || nm == 2) new_p = new_p & ~oh(nf);
            m_floor = nf;
            m_mode  = nm;
            m_pend  = new_p;
        end
    end

    always @(negedge clk) begin
        logic [12:0] exp_v;
        logic [12:0] act_v;
        if (m_valid) begin
            exp_v = {oh(m_floor), m_pend, (m_mode == 1) && m_up,
                     (m_mode == 1) && !m_up, (m_mode == 2)};
            act_v = {floor_oh, pending, moving_up, moving_down, door_open};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL model_cycle t=%0t actual=%b required=%b",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [4:0] act,
                       input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 5'b0;
        tick(2);
        chk("rst_floor", floor_oh, 5'b00001);
        chk("rst_pend", pending, 5'b00000);
        chk1("rst_door", door_open, 1'b0);
        chk1("rst_up", moving_up, 1'b0);
        chk1("rst_down", moving_down, 1'b0);
        rst = 1'b0;

        // Request at the current floor.
        req = 5'b00001;
        tick(1);
        req = 5'b0;
        chk("t1_pend_n1", pending, 5'b00001);
        chk1("t1_door_n1", door_open, 1'b0);
        tick(1);
        chk1("t1_door_n2", door_open, 1'b1);
        chk("t1_pend_n2", pending, 5'b00000);
        tick(2);
        chk1("t1_door_n4", door_open, 1'b1);
        tick(1);
        chk1("t1_door_n5", door_open, 1'b0);

        // Full climb from floor 1 to floor 5.
        req = 5'b10000;
        tick(1);
        req = 5'b0;
        chk("t2_pend_n1", pending, 5'b10000);
        chk1("t2_up_n1", moving_up, 1'b0);
        tick(1);
        chk1("t2_up_n2", moving_up, 1'b1);
        tick(4);
        chk("t2_floor_n6", floor_oh, 5'b00010);
        tick(4);
        chk("t2_floor_n10", floor_oh, 5'b00100);
        tick(4);
        chk("t2_floor_n14", floor_oh, 5'b01000);
        tick(4);
        chk("t2_floor_n18", floor_oh, 5'b10000);
        chk1("t2_door_n18", door_open, 1'b1);
        chk1("t2_up_n18", moving_up, 1'b0);
        chk("t2_pend_n18", pending, 5'b00000);
        tick(2);
        chk1("t2_door_n20", door_open, 1'b1);
        tick(1);
        chk1("t2_door_n21", door_open, 1'b0);

        // Reversal: floor 5 first, then back down to floor 1.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        req = 5'b10000;
        tick(1);
        req = 5'b0;
        tick(9);
        chk("t3_floor_n10", floor_oh, 5'b00100);
        chk1("t3_up_n10", moving_up, 1'b1);
        tick(1);
        req = 5'b00001;
        tick(1);
        req = 5'b0;
        chk("t3_pend_n12", pending, 5'b10001);
        tick(6);
        chk("t3_floor_n18", floor_oh, 5'b10000);
        chk1("t3_door_n18", door_open, 1'b1);
        chk("t3_pend_n18", pending, 5'b00001);
        tick(3);
        chk1("t3_door_n21", door_open, 1'b0);
        chk1("t3_down_n21", moving_down, 1'b0);
        tick(1);
        chk1("t3_down_n22", moving_down, 1'b1);
        tick(16);
        chk("t3_floor_n38", floor_oh, 5'b00001);
        chk1("t3_door_n38", door_open, 1'b1);
        chk("t3_pend_n38", pending, 5'b00000);

        // Same-floor request during dwell is absorbed.
        tick(1);
        req = 5'b00001;
        tick(1);
        chk1("t4_door_n40", door_open, 1'b1);
        chk("t4_pend_n40", pending, 5'b00000);
        tick(1);
        req = 5'b0;
        chk1("t4_door_n41", door_open, 1'b0);
        chk("t4_pend_n41", pending, 5'b00000);
        tick(3);
        chk1("t4_door_n44", door_open, 1'b0);

        // Reset between floors 2 and 3.
        req = 5'b11000;
        tick(1);
        req = 5'b0;
        tick(1);
        chk1("t5_up_n2", moving_up, 1'b1);
        tick(5);
        chk("t5_floor_n7", floor_oh, 5'b00010);
        chk("t5_pend_n7", pending, 5'b11000);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t5_floor_rst", floor_oh, 5'b00001);
        chk("t5_pend_rst", pending, 5'b00000);
        chk1("t5_up_rst", moving_up, 1'b0);

        // Requests above and below at once: current direction wins.
        req = 5'b00100;
        tick(1);
        req = 5'b0;
        tick(9);
        chk("t6_floor_n10", floor_oh, 5'b00100);
        chk1("t6_door_n10", door_open, 1'b1);
        tick(3);
        chk1("t6_door_n13", door_open, 1'b0);
        req = 5'b10001;
        tick(1);
        req = 5'b0;
        tick(1);
        chk1("t6_up_n15", moving_up, 1'b1);
        chk1("t6_down_n15", moving_down, 1'b0);
        tick(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
